// File: rtl/pio_pattern_sequencer.sv
// pio_pattern_sequencer: plays a table of up to eight 4-bit patterns onto an
// Avalon-MM PIO slave, one pattern per step, with a programmable dwell
// between steps. Configured and monitored through an Avalon-MM slave.
module pio_pattern_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    // configuration slave
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    // PIO master
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
);

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned PAT_W   = 4;
    localparam int unsigned N_PAT   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               ctrl_run;
    logic               ctrl_loop;
    logic               done;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   len;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] cnt;
    logic [PAT_W-1:0]   pat [N_PAT];

    logic wr_en_c;
    logic ctrl_wr_c;
    logic status_wr_c;
    logic len_wr_c;
    logic dwell_wr_c;
    logic pat_wr_c;
    logic busy_c;
    logic start_c;
    logic abort_c;
    logic step_end_c;
    logic more_c;
    logic wr_active_c;
    logic unused_ok;

    // Slave write decode and sequencing events
    assign wr_en_c     = s_chipselect & ~s_write_n;
    assign ctrl_wr_c   = wr_en_c & (s_address == 4'd0);
    assign status_wr_c = wr_en_c & (s_address == 4'd1);
    assign len_wr_c    = wr_en_c & (s_address == 4'd2);
    assign dwell_wr_c  = wr_en_c & (s_address == 4'd3);
    assign pat_wr_c    = wr_en_c & s_address[3];

    assign busy_c      = (state == S_WRITE) || (state == S_WAIT);
    assign start_c     = (state == S_IDLE) && ctrl_wr_c && s_writedata[0];
    assign abort_c     = busy_c && ctrl_wr_c && !s_writedata[0];
    assign step_end_c  = (state == S_WAIT) && (cnt == '0) && !abort_c;
    assign more_c      = idx < len;
    assign wr_active_c = (state == S_WRITE) && !abort_c;

    assign unused_ok   = ^s_writedata[31:16];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_c) state_nxt = S_WRITE;
            S_WRITE: state_nxt = abort_c ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort_c)
                    state_nxt = S_IDLE;
                else if (cnt == '0)
                    state_nxt = (more_c || ctrl_loop) ? S_WRITE : S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Step index and dwell counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            cnt <= '0;
        end else begin
            if (start_c)
                idx <= '0;
            else if (step_end_c) begin
                if (more_c)         idx <= idx + IDX_W'(1);
                else if (ctrl_loop) idx <= '0;
            end
            if (state == S_WRITE)
                cnt <= dwell;
            else if ((state == S_WAIT) && (cnt != '0))
                cnt <= cnt - DWELL_W'(1);
        end
    end

    // Done flag: setting wins over a coincident STATUS write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            done <= 1'b0;
        else if (step_end_c && !more_c && !ctrl_loop)
            done <= 1'b1;
        else if (status_wr_c || start_c)
            done <= 1'b0;
    end

    // CTRL register; run self-clears when a sequence completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_run  <= 1'b0;
            ctrl_loop <= 1'b0;
        end else begin
            if (ctrl_wr_c) begin
                ctrl_run  <= s_writedata[0];
                ctrl_loop <= s_writedata[1];
            end
            if (state == S_DONE)
                ctrl_run <= 1'b0;
        end
    end

    // LEN/DWELL are frozen while a sequence is running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len   <= IDX_W'(7);
            dwell <= '0;
        end else if (!busy_c) begin
            if (len_wr_c)   len   <= s_writedata[IDX_W-1:0];
            if (dwell_wr_c) dwell <= s_writedata[DWELL_W-1:0];
        end
    end

    // Pattern table, writable at any time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N_PAT); i++) pat[i] <= '0;
        end else if (pat_wr_c) begin
            pat[s_address[2:0]] <= s_writedata[PAT_W-1:0];
        end
    end

    // Zero-wait register readback
    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: s_readdata = {30'd0, ctrl_loop, ctrl_run};
            4'd1: s_readdata = {25'd0, idx, 2'd0, done, busy_c};
            4'd2: s_readdata = {29'd0, len};
            4'd3: s_readdata = {16'd0, dwell};
            default: begin
                if (s_address[3]) s_readdata = 32'(pat[s_address[2:0]]);
            end
        endcase
    end

    // Master drives only during an un-aborted WRITE cycle
    always_comb begin
        m_address    = 2'd0;
        m_chipselect = wr_active_c;
        m_write_n    = ~wr_active_c;
        m_writedata  = wr_active_c ? 32'(pat[idx]) : 32'd0;
    end

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Bench for pio_pattern_sequencer: directed scenarios plus randomized runs,
// expected PIO writes queued by a reference model and checked by a monitor.
module tb_pio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    pio_pattern_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         t;
        logic [3:0] d;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [3:0] pat_m [8];
    int         len_m;
    int         dwell_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every master write must match the head of the expected queue
    always @(negedge clk) begin
        chk("m_address", 32'(m_address), 32'd0);
        if (m_chipselect === 1'b1) begin
            chk("wr_strobe", 32'(m_write_n), 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got data 0x%0h at cycle %0d, expected none", m_writedata, cyc);
            end else begin
                e = q.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(e.t));
                chk("wr_data", m_writedata, {28'd0, e.d});
            end
        end else begin
            chk("idle_write_n", 32'(m_write_n), 32'd1);
            chk("idle_data", m_writedata, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        s_address = a;
        @(negedge clk);
        d = s_readdata;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pat(input int i, input logic [3:0] v);
        bus_write(4'(8 + i), 32'(v));
        pat_m[i] = v;
    endtask

    task automatic set_len(input int v);
        bus_write(4'd2, 32'(v));
        len_m = v;
    endtask

    task automatic set_dwell(input int v);
        bus_write(4'd3, 32'(v));
        dwell_m = v;
    endtask

    // Reference: step k is written at s + k*(DWELL+2) with PAT[k mod (LEN+1)]
    task automatic push_run(input int s, input int lim, input bit loop);
        int p;
        int t;
        p = dwell_m + 2;
        for (int k = 0; k < 64; k++) begin
            t = s + k * p;
            if (!loop && k > len_m) break;
            if (t >= lim) break;
            q.push_back('{t, pat_m[k % (len_m + 1)]});
        end
    endtask

    // Start a run; abort_n < 0 means no abort is planned
    task automatic start_seq(input bit loop, input int abort_n, output int s);
        int lim;
        s   = cyc + 1;
        lim = (abort_n < 0) ? 32'h7fff_ffff : s + abort_n;
        push_run(s, lim, loop);
        bus_write(4'd0, {30'd0, loop, 1'b1});
    endtask

    task automatic wait_done(input int s);
        logic [31:0] d;
        int          rc;
        bit          seen;
        seen = 1'b0;
        rc   = 0;
        d    = 32'd0;
        for (int i = 0; i < 200 && !seen; i++) begin
            rc = cyc;
            bus_read(4'd1, d);
            if (d[1]) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after 200 cycles, expected done at cycle %0d",
                     s + (len_m + 1) * (dwell_m + 2));
        end else begin
            chk("done_cycle", 32'(rc), 32'(s + (len_m + 1) * (dwell_m + 2)));
            chk("done_busy", 32'(d[0]), 32'd0);
            chk("done_idx", 32'(d[6:4]), 32'(len_m));
        end
    endtask

    task automatic do_abort(input int s, input int n);
        logic [31:0] d;
        idle(s + n - cyc);
        bus_write(4'd0, 32'd0);
        idle(3);
        bus_read(4'd1, d);
        chk("abort_status", 32'(d[1:0]), 32'd0);
    endtask

    task automatic chk_reset_regs();
        logic [31:0] d;
        bus_read(4'd0, d); chk("rst_ctrl", d, 32'd0);
        bus_read(4'd1, d); chk("rst_status", d, 32'd0);
        bus_read(4'd2, d); chk("rst_len", d, 32'd7);
        bus_read(4'd3, d); chk("rst_dwell", d, 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_read(4'(8 + i), d);
            chk("rst_pat", d, 32'd0);
        end
    endtask

    task automatic model_reset();
        len_m   = 7;
        dwell_m = 0;
        for (int i = 0; i < 8; i++) pat_m[i] = 4'd0;
    endtask

    task automatic setup_v1();
        set_pat(0, 4'h1);
        set_pat(1, 4'h2);
        set_pat(2, 4'h4);
        set_pat(3, 4'h8);
        set_len(3);
        set_dwell(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          n;
        bit          lp;
        logic [31:0] d;

        reset_n      = 1'b0;
        s_address    = 4'd0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = 32'd0;
        model_reset();
        idle(3);
        chk("rst_m_cs", 32'(m_chipselect), 32'd0);
        reset_n = 1'b1;
        idle(1);
        chk_reset_regs();

        // V1: single pass, 4-cycle step period
        setup_v1();
        start_seq(1'b0, -1, s);
        wait_done(s);

        // V6: STATUS write clears done
        bus_write(4'd1, 32'd0);
        bus_read(4'd1, d);
        chk("status_clear", 32'(d[1]), 32'd0);

        // V2: looping run, aborted in WAIT of the second pass
        start_seq(1'b1, 5 * 4 + 2, s);
        do_abort(s, 5 * 4 + 2);

        // V3: back-to-back writes, idx observed at each WRITE
        for (int i = 0; i < 8; i++) set_pat(i, 4'(i + 3));
        set_len(7);
        set_dwell(0);
        start_seq(1'b0, -1, s);
        for (int k = 0; k < 8; k++) begin
            bus_read(4'd1, d);
            chk("v3_idx", 32'(d[6:4]), 32'(k));
            chk("v3_busy", 32'(d[0]), 32'd1);
            idle(1);
        end
        wait_done(s);

        // V4: LEN/DWELL frozen while busy; PAT update picked up by later step
        setup_v1();
        pat_m[2] = 4'hF;
        start_seq(1'b0, -1, s);
        bus_write(4'd2, 32'd0);
        bus_write(4'd3, 32'd9);
        bus_write(4'd10, 32'hF);
        bus_read(4'd2, d); chk("v4_len", d, 32'd3);
        bus_read(4'd3, d); chk("v4_dwell", d, 32'd2);
        wait_done(s);

        // V6: unmapped addresses read 0 and ignore writes
        for (int a = 4; a < 8; a++) begin
            bus_write(4'(a), 32'hFFFF_FFFF);
            bus_read(4'(a), d);
            chk("unmapped", d, 32'd0);
        end

        // Randomized runs, looping ones aborted at a random cycle
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 8; i++) set_pat(i, 4'($urandom_range(0, 15)));
            set_len(int'($urandom_range(0, 7)));
            set_dwell(int'($urandom_range(0, 5)));
            lp = 1'($urandom_range(0, 1));
            if (!lp) begin
                start_seq(1'b0, -1, s);
                wait_done(s);
                bus_write(4'd1, 32'd0);
            end else begin
                n = int'($urandom_range(0, 3 * (len_m + 1) * (dwell_m + 2)));
                start_seq(1'b1, n, s);
                do_abort(s, n);
            end
        end

        // V5: reset pulsed mid-WAIT
        setup_v1();
        start_seq(1'b0, 5, s);
        idle(s + 5 - cyc);
        reset_n = 1'b0;
        #1;
        chk("v5_m_cs", 32'(m_chipselect), 32'd0);
        model_reset();
        idle(2);
        reset_n = 1'b1;
        idle(1);
        chk_reset_regs();
        start_seq(1'b0, -1, s);
        wait_done(s);

        idle(5);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_pattern_sequencer.md
PIO_PATTERN_SEQUENCER -- requirements
Module: pio_pattern_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset named as follows.
- clk  in  1  sole clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
REQ-002 The block SHALL expose an Avalon-MM configuration slave.
- s_address  in  4  register select
- s_chipselect  in  1  slave select
- s_write_n  in  1  active-low write strobe
- s_writedata  in  32  write data
- s_readdata  out  32  read data; combinational, zero-wait
REQ-003 The block SHALL expose an Avalon-MM master that drives the 4-bit output PIO slave (no waitrequest; every write accepted in one cycle).
- m_address  out  2  always 0
- m_chipselect  out  1  write cycle select
- m_write_n  out  1  active-low write strobe
- m_writedata  out  32  {28'b0, pattern nibble}

Function
REQ-004 The register map SHALL be as follows; unmapped addresses SHALL read 0 and ignore writes.
- 0 CTRL rw: bit0 run, bit1 loop
- 1 STATUS: read bit0 busy, bit1 done, bits6:4 idx; any write clears done
- 2 LEN rw: bits2:0 step count minus 1 (steps 1..8)
- 3 DWELL rw: bits15:0
- 8..15 PAT[0..7] rw: bits3:0
REQ-005 A slave write SHALL occur when s_chipselect=1 and s_write_n=0; upper unused bits SHALL read 0.
REQ-006 The FSM SHALL have states IDLE, WRITE, WAIT and DONE.
REQ-007 In IDLE, a CTRL write with bit0=1 SHALL set idx=0, clear done and enter WRITE on the next cycle.
REQ-008 WRITE SHALL last exactly one cycle: m_chipselect=1, m_write_n=0, m_writedata={28'b0,PAT[idx]}, dwell counter loaded with DWELL, next state WAIT.
REQ-009 In WAIT, the counter SHALL decrement each cycle while nonzero. When it is 0, the block SHALL leave WAIT as follows:
- idx<LEN: idx+1, go to WRITE
- idx==LEN and loop=1: idx=0, go to WRITE
- otherwise: go to DONE
REQ-010 Step period SHALL be DWELL+2 cycles; DWELL=0 SHALL give back-to-back writes every 2 cycles.
REQ-011 DONE SHALL last one cycle, set done=1, clear CTRL.run and return to IDLE.
REQ-012 busy SHALL be 1 in WRITE and WAIT and 0 in IDLE and DONE.
REQ-013 A CTRL write with bit0=0 while busy SHALL abort:
- next state IDLE
- no further master write, including one in the same cycle as the abort
- done stays 0
REQ-014 While busy, a CTRL write with bit0=1 SHALL only update loop; writes to LEN and DWELL SHALL be ignored.
REQ-015 While busy, PAT writes SHALL take effect from the next WRITE that uses that entry.
REQ-016 Outside WRITE, the master outputs SHALL be idle: m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0.
REQ-017 When a STATUS write and setting done coincide, done SHALL end at 1.

Reset
REQ-018 While reset_n=0, the block SHALL force the following, with master outputs idle immediately and without waiting for clk:
- FSM=IDLE; idx, counter, CTRL and done = 0
- LEN=7, DWELL=0, PAT[0..7]=0
REQ-019 Reset asserted mid-sequence SHALL stop all master writes in that same cycle; the PIO keeps its last written value.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- V1: PAT=1,2,4,8; LEN=3; DWELL=2; CTRL=1 -> writes 1,2,4,8 at cycles t, t+4, t+8, t+12; done=1 after the last WAIT; busy=0.
- V2: same setup with CTRL=3 -> sequence 1,2,4,8,1,2,... continues; a CTRL=0 write during WAIT -> no further writes, done=0.
- V3: DWELL=0, LEN=7 -> 8 writes spaced exactly 2 cycles apart; STATUS idx reads 0..7.
- V4: while busy, write LEN=0 and DWELL=9 -> readback unchanged and timing unchanged; a PAT[2]=0xF write before step 2 -> step 2 writes 0xF.
- V5: reset_n pulsed low mid-WAIT -> m_chipselect=0 immediately; all registers read reset values; a later CTRL=1 runs cleanly.
- V6: reads of addresses 4..7 -> 0; a write to STATUS after done -> done=0.
